// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt request-capture stage
// that feeds the 8-input priority encoder.
package irq_pkg;

  localparam int IRQ_N      = 8;
  localparam int IRQ_CODE_W = 3;

  typedef logic [IRQ_N-1:0]      irq_vec_t;
  typedef logic [IRQ_CODE_W-1:0] irq_code_t;

  // One-hot decode of an encoder code into a line vector.
  function automatic irq_vec_t code_onehot(input irq_code_t code);
    irq_vec_t v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Per-line synchronizer chain followed by a rising-edge detector.
// The edge history register resets low, so a line must fill the chain before any edge can appear.
module sync_rise #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw line through the synchronizer and remember the last synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_pending.sv
// Captures rising edges of eight asynchronous request lines as sticky pending bits,
// presents the masked vector to the priority encoder and clears bits on acknowledge.
module irq_pending
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IRQ_N-1:0] req,
  input  logic [IRQ_N-1:0] mask,
  input  logic            ack,
  input  logic [IRQ_CODE_W-1:0] ack_code,
  input  logic            clr_ovf,
  output logic [IRQ_N-1:0] pend_out,
  output logic            irq,
  output logic [IRQ_N-1:0] ovf
);

  irq_vec_t rise_s;
  irq_vec_t clr_s;
  irq_vec_t pending_q;
  irq_vec_t pending_d;
  irq_vec_t ovf_q;
  irq_vec_t ovf_d;

  for (genvar i = 0; i < IRQ_N; i++) begin : g_line
    sync_rise #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_rise (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (req[i]),
      .rise (rise_s[i])
    );
  end

  // Next-state for pending and overflow; a new edge beats a clear, clr_ovf beats a new overflow.
  always_comb begin
    clr_s     = '0;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (ack) begin
      clr_s = code_onehot(ack_code);
    end else begin
      clr_s = '0;
    end
    pending_d = rise_s | (pending_q & ~clr_s);
    if (clr_ovf) begin
      ovf_d = '0;
    end else begin
      ovf_d = ovf_q | (rise_s & pending_q & ~clr_s);
    end
  end

  // Pending and overflow state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pend_out = pending_q & ~mask;
  assign irq      = |pend_out;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_pending.sv
// Directed-vector bench for irq_pending with hand-computed expectations.
module tb_irq_pending;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_code;
  logic       clr_ovf;
  logic [7:0] pend_out;
  logic       irq;
  logic [7:0] ovf;

  int checks;
  int errors;

  irq_pending #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .ack_code(ack_code),
    .clr_ovf (clr_ovf),
    .pend_out(pend_out),
    .irq     (irq),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and return at the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_ack(input logic [2:0] code);
    ack      = 1'b1;
    ack_code = code;
    step(1);
    ack      = 1'b0;
    ack_code = 3'd0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    mask     = 8'h00;
    ack      = 1'b0;
    ack_code = 3'd0;
    clr_ovf  = 1'b0;

    // 1: reset, then single edge with 3-edge latency
    step(2);
    check_val("rst_pend", pend_out, 8'h00);
    check_val("rst_irq", {7'd0, irq}, 8'h00);
    check_val("rst_ovf", ovf, 8'h00);
    rst_n = 1'b1;
    step(2);
    req = 8'h04;
    step(2);
    check_val("lat_k1_pend", pend_out, 8'h00);
    step(1);
    check_val("lat_k2_pend", pend_out, 8'h04);
    check_val("lat_k2_irq", {7'd0, irq}, 8'h01);
    check_val("lat_k2_ovf", ovf, 8'h00);

    // 2: level held, single capture, ack clears, no recapture
    step(20);
    check_val("level_pend", pend_out, 8'h04);
    check_val("level_ovf", ovf, 8'h00);
    do_ack(3'd2);
    check_val("ack2_pend", pend_out, 8'h00);
    step(5);
    check_val("norecap_pend", pend_out, 8'h00);
    do_ack(3'd4);
    check_val("ack_idle_pend", pend_out, 8'h00);
    check_val("ack_idle_ovf", ovf, 8'h00);
    req = 8'h00;
    step(3);

    // 3: mask is combinational and does not gate capture or clear
    mask = 8'h80;
    req  = 8'h81;
    step(3);
    check_val("mask80_pend", pend_out, 8'h01);
    check_val("mask80_irq", {7'd0, irq}, 8'h01);
    mask = 8'h81;
    #1;
    check_val("mask81_irq", {7'd0, irq}, 8'h00);
    check_val("mask81_pend", pend_out, 8'h00);
    mask = 8'h00;
    #1;
    check_val("unmask_pend", pend_out, 8'h81);
    mask = 8'h80;
    do_ack(3'd7);
    mask = 8'h00;
    #1;
    check_val("ack_masked_pend", pend_out, 8'h01);
    do_ack(3'd0);
    check_val("ack0_pend", pend_out, 8'h00);
    req = 8'h00;
    step(3);

    // 4: rise and clear on the same bit in the same cycle: set wins, no overflow
    req = 8'h20;
    step(3);
    check_val("b5_set_pend", pend_out, 8'h20);
    req = 8'h00;
    step(3);
    req = 8'h20;
    step(2);
    ack      = 1'b1;
    ack_code = 3'd5;
    step(1);
    ack      = 1'b0;
    ack_code = 3'd0;
    check_val("setwins_pend", pend_out, 8'h20);
    check_val("setwins_ovf", ovf, 8'h00);
    do_ack(3'd5);
    check_val("b5_clr_pend", pend_out, 8'h00);
    req = 8'h00;
    step(3);

    // 5: overflow, clr_ovf, and clr_ovf colliding with a new overflow
    req = 8'h08;
    step(3);
    req = 8'h00;
    step(3);
    req = 8'h08;
    step(3);
    check_val("ovf3_ovf", ovf, 8'h08);
    check_val("ovf3_pend", pend_out, 8'h08);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check_val("clrovf_ovf", ovf, 8'h00);
    check_val("clrovf_pend", pend_out, 8'h08);
    req = 8'h00;
    step(3);
    req = 8'h08;
    step(2);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check_val("clrovf_wins_ovf", ovf, 8'h00);
    do_ack(3'd3);
    req = 8'h00;
    step(3);

    // 6: asynchronous reset mid-operation, then no early capture after release
    req = 8'hFF;
    step(3);
    check_val("allpend_pend", pend_out, 8'hFF);
    req = 8'hEF;
    step(3);
    req = 8'hFF;
    step(3);
    check_val("pre_rst_ovf", ovf, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_pend", pend_out, 8'h00);
    check_val("async_rst_irq", {7'd0, irq}, 8'h00);
    check_val("async_rst_ovf", ovf, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(1);
    check_val("post_rel1_pend", pend_out, 8'h00);
    step(1);
    check_val("post_rel2_pend", pend_out, 8'h00);
    check_val("post_rel2_ovf", ovf, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
